// File: rtl/mdc_r2_stage.sv
`default_nettype none
// ============================================================================
// Module      : mdc_r2_stage
// Description : Radix-2 multi-path delay commutator (MDC) stage. It reorders
//               two complex sample streams through a pair of DEPTH-beat delay
//               lines and a commutator, then applies a registered radix-2
//               butterfly. The butterfly result is either saturated to WIDTH
//               bits or scaled by 1/2 (floor).
// Revision    : 1.0 - initial release
// ============================================================================
module mdc_r2_stage #(
  parameter int WIDTH      = 9,
  parameter int DEPTH      = 1,
  parameter int SCALE_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_lo_re,
  input  logic signed [WIDTH-1:0] in_lo_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_up_re,
  output logic signed [WIDTH-1:0] out_up_im,
  output logic signed [WIDTH-1:0] out_lo_re,
  output logic signed [WIDTH-1:0] out_lo_im
);

  // Bit of the beat counter that selects the commutator position.
  localparam int c_log_d  = (DEPTH > 1) ? $clog2(DEPTH) : 0;
  // Counter spans 2*DEPTH beats, so one bit more than the select index.
  localparam int c_cnt_w  = c_log_d + 1;
  // Fill count needs to represent 0..DEPTH inclusive.
  localparam int c_fill_w = $clog2(DEPTH + 1);
  // A delay-line word holds {re, im}.
  localparam int c_smp_w  = 2 * WIDTH;

  localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(DEPTH);
  localparam logic [WIDTH-1:0]    c_min      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]    c_max      = {1'b0, {(WIDTH-1){1'b1}}};

  // Reduce a WIDTH+1 bit butterfly result back to WIDTH bits.
  function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] v);
    logic [WIDTH-1:0] r;
    if (SCALE_MODE == 1) begin
      // Dropping the LSB of a two's-complement value is a floor divide by 2.
      r = v[WIDTH:1];
    end else if (v[WIDTH] != v[WIDTH-1]) begin
      // Top two bits disagree: the value left the WIDTH-bit range.
      r = v[WIDTH] ? c_min : c_max;
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0]                cnt_q,  cnt_d;
  logic [c_fill_w-1:0]               fill_q, fill_d;
  logic [DEPTH-1:0][c_smp_w-1:0]     d1_q,   d1_d;
  logic [DEPTH-1:0][c_smp_w-1:0]     d2_q,   d2_d;
  logic                              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]                  out_up_re_q, out_up_re_d;
  logic [WIDTH-1:0]                  out_up_im_q, out_up_im_d;
  logic [WIDTH-1:0]                  out_lo_re_q, out_lo_re_d;
  logic [WIDTH-1:0]                  out_lo_im_q, out_lo_im_d;

  // --------------------------------------------------------------------------
  // Datapath wires
  // --------------------------------------------------------------------------
  logic                              w_accept;
  logic                              w_sel;
  logic [c_smp_w-1:0]                w_in_up;
  logic [c_smp_w-1:0]                w_in_lo;
  logic [c_smp_w-1:0]                w_d1;
  logic [c_smp_w-1:0]                w_com_up;
  logic [c_smp_w-1:0]                w_com_lo;
  logic [c_smp_w-1:0]                w_a;
  logic [c_smp_w-1:0]                w_b;
  logic [WIDTH-1:0]                  w_a_re, w_a_im, w_b_re, w_b_im;
  logic [WIDTH:0]                    w_sum_re, w_sum_im, w_dif_re, w_dif_im;
  logic [DEPTH-1:0][c_smp_w-1:0]     w_d1_shift;
  logic [DEPTH-1:0][c_smp_w-1:0]     w_d2_shift;

  // A beat presented together with flush is dropped.
  assign w_accept = in_valid & ~flush;
  assign w_sel    = cnt_q[c_log_d];

  assign w_in_up  = {in_up_re, in_up_im};
  assign w_in_lo  = {in_lo_re, in_lo_im};
  assign w_d1     = d1_q[DEPTH-1];

  // Commutator: swap which stream feeds D2 and which goes straight through.
  assign w_com_up = w_sel ? w_d1    : w_in_up;
  assign w_com_lo = w_sel ? w_in_up : w_d1;

  assign w_a      = d2_q[DEPTH-1];
  assign w_b      = w_com_lo;
  assign w_a_re   = w_a[c_smp_w-1:WIDTH];
  assign w_a_im   = w_a[WIDTH-1:0];
  assign w_b_re   = w_b[c_smp_w-1:WIDTH];
  assign w_b_im   = w_b[WIDTH-1:0];

  // Butterfly at one extra bit so the sum/difference never wraps.
  assign w_sum_re = {w_a_re[WIDTH-1], w_a_re} + {w_b_re[WIDTH-1], w_b_re};
  assign w_sum_im = {w_a_im[WIDTH-1], w_a_im} + {w_b_im[WIDTH-1], w_b_im};
  assign w_dif_re = {w_a_re[WIDTH-1], w_a_re} - {w_b_re[WIDTH-1], w_b_re};
  assign w_dif_im = {w_a_im[WIDTH-1], w_a_im} - {w_b_im[WIDTH-1], w_b_im};

  // Shifted delay-line images; a single-entry line has nothing to carry over.
  if (DEPTH == 1) begin : g_shift_one
    assign w_d1_shift = w_in_lo;
    assign w_d2_shift = w_com_up;
  end else begin : g_shift_many
    assign w_d1_shift = {d1_q[DEPTH-2:0], w_in_lo};
    assign w_d2_shift = {d2_q[DEPTH-2:0], w_com_up};
  end

  // Next-state: everything advances on accepted beats only; flush restarts
  // the beat count and fill tracking but leaves line contents alone.
  always_comb begin
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    out_valid_d = w_accept && (fill_q == c_fill_max);
    out_up_re_d = out_up_re_q;
    out_up_im_d = out_up_im_q;
    out_lo_re_d = out_lo_re_q;
    out_lo_im_d = out_lo_im_q;

    if (flush) begin
      cnt_d  = '0;
      fill_d = '0;
    end else if (w_accept) begin
      // 2*DEPTH is a power of two, so natural rollover is the modulo wrap.
      cnt_d = cnt_q + c_cnt_w'(1);
      if (fill_q != c_fill_max) begin
        fill_d = fill_q + c_fill_w'(1);
      end
      d1_d        = w_d1_shift;
      d2_d        = w_d2_shift;
      out_up_re_d = fit(w_sum_re);
      out_up_im_d = fit(w_sum_im);
      out_lo_re_d = fit(w_dif_re);
      out_lo_im_d = fit(w_dif_im);
    end
  end

  // State registers with asynchronous clear of all stored data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      fill_q      <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      out_valid_q <= 1'b0;
      out_up_re_q <= '0;
      out_up_im_q <= '0;
      out_lo_re_q <= '0;
      out_lo_im_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      out_valid_q <= out_valid_d;
      out_up_re_q <= out_up_re_d;
      out_up_im_q <= out_up_im_d;
      out_lo_re_q <= out_lo_re_d;
      out_lo_im_q <= out_lo_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_up_re = out_up_re_q;
  assign out_up_im = out_up_im_q;
  assign out_lo_re = out_lo_re_q;
  assign out_lo_im = out_lo_im_q;

endmodule
`default_nettype wire

// File: tb/tb_mdc_r2_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdc_r2_stage
// Description : Self-checking bench for mdc_r2_stage. Four instances with
//               different DEPTH / SCALE_MODE share one input stream; a
//               history-based reference model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdc_r2_stage;

  localparam int W    = 9;
  localparam int NDUT = 4;

  function automatic int dep_of(input int k);
    case (k)
      0:       return 1;
      1:       return 1;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int scl_of(input int k);
    return k % 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] in_up_re = '0, in_up_im = '0, in_lo_re = '0, in_lo_im = '0;

  logic                ov  [NDUT];
  logic signed [W-1:0] our [NDUT];
  logic signed [W-1:0] oui [NDUT];
  logic signed [W-1:0] olr [NDUT];
  logic signed [W-1:0] oli [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    mdc_r2_stage #(
      .WIDTH      (W),
      .DEPTH      (dep_of(k)),
      .SCALE_MODE (scl_of(k))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_up_re  (in_up_re),
      .in_up_im  (in_up_im),
      .in_lo_re  (in_lo_re),
      .in_lo_im  (in_lo_im),
      .out_valid (ov[k]),
      .out_up_re (our[k]),
      .out_up_im (oui[k]),
      .out_lo_re (olr[k]),
      .out_lo_im (oli[k])
    );
  end

  // Reference model state: accepted-beat history since reset/flush.
  int hu_re[$], hu_im[$], hl_re[$], hl_im[$];
  int ev  [NDUT];
  bit kn  [NDUT];
  int eur [NDUT], eui[NDUT], elr[NDUT], eli[NDUT];

  int tests = 0;
  int fails = 0;

  function automatic int fitv(input int s, input int scl);
    if (scl != 0) return s >>> 1;
    if (s > 255)  return 255;
    if (s < -256) return -256;
    return s;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s/d%0d/valid", ph, k), 32'(ov[k]), ev[k]);
      if (kn[k]) begin
        chk($sformatf("%s/d%0d/up_re", ph, k), 32'(our[k]), eur[k]);
        chk($sformatf("%s/d%0d/up_im", ph, k), 32'(oui[k]), eui[k]);
        chk($sformatf("%s/d%0d/lo_re", ph, k), 32'(olr[k]), elr[k]);
        chk($sformatf("%s/d%0d/lo_im", ph, k), 32'(oli[k]), eli[k]);
      end
    end
  endtask

  task automatic model_clear();
    hu_re.delete(); hu_im.delete(); hl_re.delete(); hl_im.delete();
  endtask

  // Prediction for the newest beat: pairing depends only on beat index.
  task automatic model_beat();
    int n, d, ar, ai, br, bi, s;
    n = hu_re.size() - 1;
    for (int k = 0; k < NDUT; k++) begin
      d = dep_of(k);
      s = scl_of(k);
      if (n < d) begin
        ev[k] = 0;
        kn[k] = 1'b0;
      end else begin
        if ((n % (2 * d)) >= d) begin
          ar = hu_re[n-d];   ai = hu_im[n-d];
          br = hu_re[n];     bi = hu_im[n];
        end else begin
          ar = hl_re[n-2*d]; ai = hl_im[n-2*d];
          br = hl_re[n-d];   bi = hl_im[n-d];
        end
        ev[k]  = 1;
        kn[k]  = 1'b1;
        eur[k] = fitv(ar + br, s);
        eui[k] = fitv(ai + bi, s);
        elr[k] = fitv(ar - br, s);
        eli[k] = fitv(ai - bi, s);
      end
    end
  endtask

  task automatic beat(input bit v, input bit f, input int ur, input int ui,
                      input int lr, input int li, input string ph);
    @(negedge clk);
    in_valid = v;
    flush    = f;
    in_up_re = W'(ur);
    in_up_im = W'(ui);
    in_lo_re = W'(lr);
    in_lo_im = W'(li);
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) ev[k] = 0;
    if (f) begin
      model_clear();
    end else if (v) begin
      hu_re.push_back(ur); hu_im.push_back(ui);
      hl_re.push_back(lr); hl_im.push_back(li);
      model_beat();
    end
    check_all(ph);
  endtask

  // Reset pulse: outputs must clear before any clock edge arrives.
  task automatic do_reset(input string ph);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < NDUT; k++) begin
      ev[k] = 0; kn[k] = 1'b1;
      eur[k] = 0; eui[k] = 0; elr[k] = 0; eli[k] = 0;
    end
    check_all(ph);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  initial begin
    int  acc;
    bit  flushed;
    bit  v;

    do_reset("por");

    // Basic DEPTH=1 pairing.
    beat(1, 0, 10, 0, 3, 0, "r27b0");
    chk("r27b0_valid", 32'(ov[0]), 0);
    beat(1, 0, 20, 0, 4, 0, "r27b1");
    chk("r27b1_up_re", 32'(our[0]), 30);
    chk("r27b1_lo_re", 32'(olr[0]), -10);
    beat(1, 0, 0, 0, 0, 0, "r27b2");
    chk("r27b2_up_re", 32'(our[0]), 7);
    chk("r27b2_lo_re", 32'(olr[0]), -1);

    // Saturation versus scaling on the same stimulus.
    do_reset("r28rst");
    beat(1, 0, 200, -200, 0, 0, "r28b0");
    beat(1, 0, 100, -100, 0, 0, "r28b1");
    chk("r28_sat_up_re", 32'(our[0]), 255);
    chk("r28_sat_up_im", 32'(oui[0]), -256);
    chk("r28_sat_lo_re", 32'(olr[0]), 100);
    chk("r28_sat_lo_im", 32'(oli[0]), -100);
    chk("r29_scl_up_re", 32'(our[1]), 150);
    chk("r29_scl_up_im", 32'(oui[1]), -150);
    chk("r29_scl_lo_re", 32'(olr[1]), 50);
    chk("r29_scl_lo_im", 32'(oli[1]), -50);

    // Floor behaviour of the scaled path on a negative odd sum.
    do_reset("r29rst");
    beat(1, 0, -3, 0, 0, 0, "r29b0");
    beat(1, 0, 0, 0, 0, 0, "r29b1");
    chk("r29_floor_up_re", 32'(our[1]), -2);

    // Hold across a gap, then flush with a beat presented (not accepted).
    beat(0, 0, 77, 77, 77, 77, "gap");
    beat(1, 1, 55, 55, 55, 55, "flush0");

    // Random stream with gaps and a flush after five accepted beats.
    acc = 0;
    flushed = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (acc == 5 && !flushed) begin
        beat(1, 1, rnd(), rnd(), rnd(), rnd(), "rflush");
        flushed = 1'b1;
        acc = 0;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        beat(v, 0, rnd(), rnd(), rnd(), rnd(), "rand1");
        if (v) acc++;
      end
    end

    // Reset mid-stream, then continue with random traffic.
    do_reset("midrst");
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 9) < 7);
      beat(v, 0, rnd(), rnd(), rnd(), rnd(), "rand2");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
